// File: rtl/farm_sensor_conditioner.sv
// Farm-road vehicle sensor conditioning: sync, debounce, vehicle counting and
// a lockout FSM that raises the farm request C to the highway light controller.
module farm_sensor_conditioner #(
    parameter int DEB_CYCLES    = 4,
    parameter int TICK_DIV      = 4,
    parameter int MIN_HWY_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic [2:0] light_highway,
    input  logic [2:0] light_farm,
    output logic       C,
    output logic [3:0] vehicle_cnt
);

    localparam int RW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int LW = $clog2(MIN_HWY_TICKS + 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(MIN_HWY_TICKS - 1);
    localparam logic [2:0]    GREEN     = 3'b001;

    typedef enum logic [1:0] {HWY_LOCK, HWY_OPEN, REQ, SERVE} state_t;

    state_t          state, state_d;
    logic            sync1, sync2;
    logic            deb, deb_q;
    logic [RW-1:0]   run;
    logic [TW-1:0]   tick_cnt;
    logic [LW-1:0]   lock_cnt;
    logic            farm_green_q;
    logic            tick, arrive, farm_green, hwy_green;

    assign tick       = (tick_cnt == TICK_LAST);
    assign arrive     = deb && !deb_q;
    assign farm_green = (light_farm == GREEN);
    assign hwy_green  = (light_highway == GREEN);
    assign C          = (state == REQ);

    // Sensor path: two-flop synchronizer feeding a run-length debouncer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            run   <= '0;
        end else begin
            sync1 <= sensor_raw;
            sync2 <= sync1;
            deb_q <= deb;
            if (sync2 != deb) begin
                if (run == RUN_LAST) begin
                    deb <= sync2;
                    run <= '0;
                end else begin
                    run <= run + RW'(1);
                end
            end else begin
                run <= '0;
            end
        end
    end

    // Queue clears on the first farm-green edge; the clear beats a same-cycle arrival
    always_ff @(posedge clk) begin
        if (rst) begin
            vehicle_cnt  <= 4'd0;
            farm_green_q <= 1'b0;
        end else begin
            farm_green_q <= farm_green;
            if (farm_green && !farm_green_q)
                vehicle_cnt <= 4'd0;
            else if (arrive && !farm_green && vehicle_cnt != 4'd15)
                vehicle_cnt <= vehicle_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            lock_cnt <= '0;
            state    <= HWY_LOCK;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (state != HWY_LOCK)
                lock_cnt <= '0;
            else if (tick)
                lock_cnt <= lock_cnt + LW'(1);
            state <= state_d;
        end
    end

    // Any loss of highway green means the controller is already serving the farm road
    always_comb begin
        state_d = state;
        case (state)
            HWY_LOCK: begin
                if (!hwy_green)
                    state_d = SERVE;
                else if (tick && lock_cnt == LOCK_LAST)
                    state_d = HWY_OPEN;
            end
            HWY_OPEN: begin
                if (!hwy_green)
                    state_d = SERVE;
                else if (vehicle_cnt != 4'd0)
                    state_d = REQ;
            end
            REQ:      if (!hwy_green) state_d = SERVE;
            SERVE:    if (hwy_green)  state_d = HWY_LOCK;
            default:  state_d = HWY_LOCK;
        endcase
    end

endmodule

// File: doc/farm_sensor_conditioner.md
FARM_SENSOR_CONDITIONER -- requirements
Module: farm_sensor_conditioner

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4: consecutive clocks a synchronized sensor level must differ before it is accepted.
REQ-002 The block SHALL have parameter TICK_DIV, default 4: clocks per 1 s tick (50000000 on a 50 MHz FPGA).
REQ-003 The block SHALL have parameter MIN_HWY_TICKS, default 5: minimum highway-green ticks before a farm request is issued.
REQ-004 The block SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port sensor_raw, input, 1: asynchronous, bouncy farm-road vehicle loop; 1 = vehicle present.
REQ-007 The block SHALL have port light_highway, input, 3: controller highway lamps (100 red, 010 yellow, 001 green).
REQ-008 The block SHALL have port light_farm, input, 3: controller farm lamps, same encoding.
REQ-009 The block SHALL have port C, output, 1: registered farm-road request to the light controller.
REQ-010 The block SHALL have port vehicle_cnt, output, 4: registered count of vehicles waiting on the farm road.

Function
REQ-011 Synchronizer: sensor_raw SHALL pass through two flops before any other use.
REQ-012 Debounce: the debounced level SHALL change on the DEB_CYCLES-th consecutive edge at which the synchronized sample differs from it; any matching sample SHALL clear the run counter.
REQ-013 Arrival: a debounced 0->1 transition SHALL increment vehicle_cnt on the following edge.
REQ-014 vehicle_cnt SHALL saturate at 15; further arrivals SHALL be ignored, with no wrap.
REQ-015 Arrivals SHALL be ignored while light_farm == 001.
REQ-016 vehicle_cnt SHALL clear on the edge at which light_farm first becomes 001; a simultaneous arrival SHALL lose to the clear.
REQ-017 Tick: a free-running counter 0..TICK_DIV-1 SHALL pulse tick for one clock at count TICK_DIV-1, then wrap to 0.
REQ-018 FSM states SHALL be HWY_LOCK, HWY_OPEN, REQ and SERVE.
REQ-019 In HWY_LOCK, the lock counter SHALL increment on each tick and go to HWY_OPEN on the tick where it equals MIN_HWY_TICKS-1.
REQ-020 In HWY_OPEN, the FSM SHALL go to REQ when vehicle_cnt != 0.
REQ-021 In REQ, the FSM SHALL go to SERVE on the first edge where light_highway != 001.
REQ-022 In SERVE, the FSM SHALL return to HWY_LOCK with the lock counter zeroed when light_highway == 001.
REQ-023 In HWY_LOCK or HWY_OPEN, light_highway != 001 SHALL force the FSM to SERVE.
REQ-024 C SHALL be 1 exactly in the cycles the FSM is in REQ, with zero added latency from the state register.
REQ-025 C SHALL never assert during HWY_LOCK, even when vehicle_cnt != 0.
REQ-026 Arrivals in any state except farm green SHALL count.
REQ-027 Vehicles arriving during farm yellow SHALL therefore raise C after the next lockout.

Reset
REQ-028 With rst high at an edge: synchronizer flops, debounced level, run, tick and lock counters all 0; vehicle_cnt = 0; C = 0; FSM = HWY_LOCK.
REQ-029 Reset asserted mid-operation, including in REQ, SHALL drop C on that edge and restart the lockout.
REQ-030 Reset SHALL dominate arrivals and the light inputs on the same edge.

Verification (defaults; lights held highway 001, farm 100 unless stated)
REQ-031 Scenario 1: hold rst 3 cycles -> C = 0, vehicle_cnt = 0, FSM = HWY_LOCK on the first edge.
REQ-032 Scenario 2: toggle sensor_raw every 2 cycles for 24 cycles, then hold 0 -> vehicle_cnt stays 0 and C stays 0.
REQ-033 Scenario 3: raw pulse 10 cycles wide, cycles 5-14 after reset -> vehicle_cnt = 1 by cycle 12; C = 0 until lockout expiry (5 ticks = 20 cycles); C = 1 by cycle 22.
REQ-034 Scenario 4 (REQ with C = 1): light_highway = 010 -> C = 0 next edge. Then light_farm = 001 -> vehicle_cnt = 0. A 10-cycle pulse during farm green -> count stays 0.
REQ-035 Scenario 5 (farm yellow): 10-cycle pulse -> vehicle_cnt = 1. Then light_highway = 001 -> C held 0 for 20 cycles, then C = 1.
REQ-036 Scenario 6: 17 clean pulses 10 cycles apart -> vehicle_cnt = 15, no wrap. Then rst for 1 cycle while in REQ -> C = 0 and vehicle_cnt = 0 on that edge.
